gear_corr_seq: RTL and testbench

Multi-cycle sequencer around a GeAr (Generic Accuracy-configurable) approximate adder with error detection and bounded iterative correction. It accepts an operand pair over a valid/ready handshake and produces the speculative GeAr sum in one cycle. It then spends up to a programmable number of extra cycles correcting erroneous sub-adder windows, lowest window first, before returning the result. It sits between the systolic-array accumulation path and the approximate adder datapath, and trades latency against accuracy per operation.

---
 rtl/gear_corr_seq.sv | 154 +++++++++++++++
 tb/tb_gear_corr_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gear_corr_seq.sv
// Sequencer around a GeAr approximate adder: one-cycle speculative sum, then
// bounded lowest-window-first correction of mispredicted windows.
module gear_corr_seq #(
    parameter int N = 64,
    parameter int R = 8,
    parameter int P = 8,
    localparam int L = R + P,
    localparam int K = 1 + (N - L) / R,
    localparam int CW = $clog2(K)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic [N-1:0]  i_a,
    input  logic [N-1:0]  i_b,
    input  logic [CW-1:0] i_corr_max,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [N-1:0]  o_sum,
    output logic          o_exact,
    output logic [K-2:0]  o_err_flags,
    output logic [CW-1:0] o_ncorr,
    output logic          o_valid,
    input  logic          i_ready
);

    // state    | meaning
    // S_IDLE   | waiting for a request, o_ready high
    // S_APPROX | operands held, speculative sum and flags being captured
    // S_CORR   | one flagged window repaired per cycle
    // S_DONE   | result presented, waiting for i_ready

    if ((N - L) % R != 0) begin : g_bad_cfg
        $error("gear_corr_seq: (N-L) must be a multiple of R");
    end

    typedef enum logic [1:0] {S_IDLE, S_APPROX, S_CORR, S_DONE} state_t;

    localparam logic [CW-1:0] CMAX_LIM = CW'(K - 1);

    state_t        state;
    state_t        state_nxt;

    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [CW-1:0] cmax_r;
    logic [K-2:0]  corr_done;

    logic [CW-1:0] cmax_sat;
    logic [N-1:0]  exact_sum;
    logic [N-1:0]  approx_sum;
    logic [K-2:0]  approx_flags;
    logic [L-1:0]  win_sum;

    logic [K-2:0]  pending;
    logic [K-2:0]  low_sel;
    logic [K-2:0]  pending_after;
    logic [N-1:0]  corr_sum;
    logic [CW-1:0] cnt_next;
    logic          last_corr;

    assign cmax_sat  = (i_corr_max > CMAX_LIM) ? CMAX_LIM : i_corr_max;
    assign exact_sum = a_r + b_r;

    // Every window adds its L-bit slice with carry-in 0; only window 0 keeps
    // its low P bits, the others contribute just their top R bits.
    always_comb begin
        approx_sum   = '0;
        approx_flags = '0;
        win_sum      = a_r[L-1:0] + b_r[L-1:0];
        approx_sum[L-1:0] = win_sum;
        for (int i = 1; i < K; i++) begin
            win_sum = a_r[i*R +: L] + b_r[i*R +: L];
            approx_sum[i*R+P +: R] = win_sum[P +: R];
            approx_flags[i-1]      = (win_sum[P +: R] != exact_sum[i*R+P +: R]);
        end
    end

    assign pending       = o_err_flags & ~corr_done;
    assign low_sel       = pending & (~pending + (K-1)'(1));
    assign pending_after = pending & ~low_sel;
    assign cnt_next      = o_ncorr + CW'(1);
    assign last_corr     = (pending_after == '0) || (cnt_next >= cmax_r);

    always_comb begin
        corr_sum = o_sum;
        for (int i = 1; i < K; i++) begin
            if (low_sel[i-1]) begin
                corr_sum[i*R+P +: R] = exact_sum[i*R+P +: R];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (i_valid) state_nxt = S_APPROX;
            S_APPROX: state_nxt = ((|approx_flags) && (cmax_r != '0)) ? S_CORR : S_DONE;
            S_CORR:   if (last_corr) state_nxt = S_DONE;
            S_DONE:   if (i_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == S_IDLE);
        o_valid = (state == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            a_r         <= '0;
            b_r         <= '0;
            cmax_r      <= '0;
            corr_done   <= '0;
            o_sum       <= '0;
            o_err_flags <= '0;
            o_ncorr     <= '0;
            o_exact     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_r     <= i_a;
                        b_r     <= i_b;
                        cmax_r  <= cmax_sat;
                        o_ncorr <= '0;
                    end
                end
                S_APPROX: begin
                    o_sum       <= approx_sum;
                    o_err_flags <= approx_flags;
                    corr_done   <= '0;
                    o_exact     <= ~|approx_flags;
                end
                S_CORR: begin
                    o_sum     <= corr_sum;
                    corr_done <= corr_done | low_sel;
                    o_ncorr   <= cnt_next;
                    o_exact   <= ~|pending_after;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gear_corr_seq.sv
// Bench for gear_corr_seq: directed table, random ops against a window-level
// reference model, plus stall and mid-correction reset sequences.
module tb_gear_corr_seq;

    logic        i_clk;
    logic        i_rstn;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic [2:0]  i_corr_max;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] o_sum;
    logic        o_exact;
    logic [5:0]  o_err_flags;
    logic [2:0]  o_ncorr;
    logic        o_valid;
    logic        i_ready;

    int errors = 0;
    int checks = 0;

    gear_corr_seq dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_corr_max  (i_corr_max),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_sum       (o_sum),
        .o_exact     (o_exact),
        .o_err_flags (o_err_flags),
        .o_ncorr     (o_ncorr),
        .o_valid     (o_valid),
        .i_ready     (i_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  cm;
        logic [63:0] sum;
        logic [5:0]  flags;
        int          nc;
        logic        ex;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: 7 windows of 16 bits at 8-bit stride; windows 1..6 give
    // their upper byte. Repair flagged windows lowest first up to the budget.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input int cm,
                                  output logic [63:0] s, output logic [5:0] fl,
                                  output int nc, output logic ex);
        logic [63:0] exact;
        logic [63:0] mask;
        logic [15:0] wa;
        logic [15:0] wb;
        logic [15:0] ws;
        int          budget;
        int          nflag;
        exact  = a + b;
        budget = (cm > 6) ? 6 : cm;
        wa = a[15:0];
        wb = b[15:0];
        ws = wa + wb;
        s  = {48'b0, ws};
        fl = '0;
        nc = 0;
        nflag = 0;
        for (int w = 1; w < 7; w++) begin
            wa = 16'(a >> (w * 8));
            wb = 16'(b >> (w * 8));
            ws = wa + wb;
            s  = s | ({56'b0, ws[15:8]} << (w * 8 + 8));
            if (ws[15:8] != 8'(exact >> (w * 8 + 8))) begin
                fl[w-1] = 1'b1;
                nflag++;
            end
        end
        for (int w = 1; w < 7; w++) begin
            if (fl[w-1] && nc < budget) begin
                mask = 64'hFF << (w * 8 + 8);
                s    = (s & ~mask) | (exact & mask);
                nc++;
            end
        end
        ex = (nc == nflag);
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] cm);
        int n;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        i_a = a;
        i_b = b;
        i_corr_max = cm;
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [63:0] s, input logic [5:0] fl,
                            input int nc, input logic ex, input int lat);
        chk({tag, " valid"}, {63'b0, o_valid}, 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(1 + nc));
        chk({tag, " sum"}, o_sum, s);
        chk({tag, " flags"}, {58'b0, o_err_flags}, {58'b0, fl});
        chk({tag, " ncorr"}, {61'b0, o_ncorr}, 64'(nc));
        chk({tag, " exact"}, {63'b0, o_exact}, {63'b0, ex});
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [2:0]  rcm;
        logic [63:0] es;
        logic [5:0]  ef;
        int          enc;
        logic        eex;
        int          lat;
        int          seen;

        vecs[0] = '{64'h1234, 64'h1111, 3'd3, 64'h2345, 6'h00, 0, 1'b1};
        vecs[1] = '{64'hFFFF, 64'h1, 3'd0, 64'h0, 6'h01, 0, 1'b0};
        vecs[2] = '{64'hFFFF, 64'h1, 3'd1, 64'h10000, 6'h01, 1, 1'b1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd3, 64'hFFFF_FF00_0000_0000, 6'h3F, 3, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd7, 64'h0, 6'h3F, 6, 1'b1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd0, 64'hFFFF_FFFF_FFFF_0000, 6'h3F, 0, 1'b0};

        i_rstn = 1'b0;
        i_a = '0;
        i_b = '0;
        i_corr_max = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        #2;
        chk("reset ready", {63'b0, o_ready}, 64'd1);
        chk("reset valid", {63'b0, o_valid}, 64'd0);
        chk("reset sum", o_sum, 64'd0);
        chk("reset flags", {58'b0, o_err_flags}, 64'd0);
        chk("reset ncorr", {61'b0, o_ncorr}, 64'd0);
        chk("reset exact", {63'b0, o_exact}, 64'd0);
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cm);
            wait_valid(lat);
            check_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].flags, vecs[i].nc, vecs[i].ex, lat);
            release_result();
        end

        for (int i = 0; i < 60; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: rb = {$urandom, $urandom};
                1: rb = ~ra + 64'($urandom_range(1, 255));
                default: rb = (~ra & {$urandom, $urandom}) | 64'($urandom_range(0, 3));
            endcase
            rcm = 3'($urandom_range(0, 7));
            model(ra, rb, int'(rcm), es, ef, enc, eex);
            send(ra, rb, rcm);
            wait_valid(lat);
            check_op($sformatf("rnd%0d", i), es, ef, enc, eex, lat);
            release_result();
        end

        // Stall in DONE with a competing request that must be ignored.
        send(64'h1234, 64'h1111, 3'd3);
        wait_valid(lat);
        i_a = 64'hFFFF;
        i_b = 64'h1;
        i_corr_max = 3'd1;
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            chk($sformatf("stall%0d valid", c), {63'b0, o_valid}, 64'd1);
            chk($sformatf("stall%0d ready", c), {63'b0, o_ready}, 64'd0);
            chk($sformatf("stall%0d sum", c), o_sum, 64'h2345);
            chk($sformatf("stall%0d ncorr", c), {61'b0, o_ncorr}, 64'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("idle ready", {63'b0, o_ready}, 64'd1);
        chk("idle valid", {63'b0, o_valid}, 64'd0);
        chk("idle sum held", o_sum, 64'h2345);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        wait_valid(lat);
        check_op("second", 64'h10000, 6'h01, 1, 1'b1, lat);
        release_result();

        // Reset in the second correction cycle discards the operation.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd6);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("corr2 ncorr", {61'b0, o_ncorr}, 64'd1);
        i_rstn = 1'b0;
        #1;
        chk("rst ready", {63'b0, o_ready}, 64'd1);
        chk("rst valid", {63'b0, o_valid}, 64'd0);
        chk("rst sum", o_sum, 64'd0);
        chk("rst flags", {58'b0, o_err_flags}, 64'd0);
        chk("rst ncorr", {61'b0, o_ncorr}, 64'd0);
        chk("rst exact", {63'b0, o_exact}, 64'd0);
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        chk("no valid after reset", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
